// File: rtl/cu_pkg.sv
// Shared definitions for the multicycle control unit: state encoding,
// RV32 opcode constants and exception cause codes.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_WB     = 3'd3,
    ST_INTR   = 3'd4,
    ST_LDWAIT = 3'd5,
    ST_STWAIT = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_FETCH_TO = 2'd2,
    CAUSE_DATA_TO  = 2'd3
  } cause_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_SYSTEM, OP_RTYPE,
      OP_ITYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_wait_timer.sv
// Counts memory wait cycles and flags when the allowed budget is used up.
module cu_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // A cycle that both changes state and waits starts the new count at one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? CW'(1) : '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  if (TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    assign expired = (cnt_q >= CW'(TIMEOUT - 1));
  end

endmodule

// File: rtl/cu_fsm_ws.sv
// Multicycle RISC-V control unit: fetch/execute/load-store wait/writeback
// sequencing with memory handshakes, bus timeouts, interrupts and traps.
module cu_fsm_ws
  import cu_pkg::*;
#(
  parameter int TIMEOUT       = 16,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR,
  input  logic       CSR_MIE,
  input  logic [6:0] OPCODE,
  input  logic [2:0] FUNC3,
  input  logic       IMEM_RDY,
  input  logic       DMEM_RDY,
  output logic       PC_WR,
  output logic       RF_WR,
  output logic       CSR_WE,
  output logic       MEM_RE1,
  output logic       MEM_RE2,
  output logic       MEM_WE2,
  output logic       RESET,
  output logic       INT_TAKEN,
  output logic       EXC_TAKEN,
  output logic [1:0] EXC_CAUSE,
  output logic [2:0] STATE
);

  state_t state_q, state_d;
  cause_t cause_q, cause_d;
  state_t retire_state;
  logic   store_stall;
  logic   timer_clr, timer_inc, timer_expired;

  assign retire_state = (INTR && CSR_MIE) ? ST_INTR : ST_FETCH;
  assign store_stall  = (OPCODE == OP_STORE) && !DMEM_RDY;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_INIT;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // RDY arrival is tested before the timeout so a last-cycle RDY succeeds.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_INIT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (IMEM_RDY) begin
          state_d = ST_EXEC;
        end else if (timer_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TO;
        end
      end
      ST_EXEC: begin
        if (OPCODE == OP_LOAD) begin
          state_d = ST_LDWAIT;
        end else if (OPCODE == OP_STORE) begin
          state_d = DMEM_RDY ? retire_state : ST_STWAIT;
        end else if (CHECK_ILLEGAL && !is_legal_op(OPCODE)) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = retire_state;
        end
      end
      ST_LDWAIT, ST_STWAIT: begin
        if (DMEM_RDY) begin
          state_d = (state_q == ST_LDWAIT) ? ST_WB : retire_state;
        end else if (timer_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DATA_TO;
        end
      end
      ST_WB:    state_d = retire_state;
      ST_INTR:  state_d = ST_FETCH;
      ST_TRAP:  state_d = ST_FETCH;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    PC_WR     = 1'b0;
    RF_WR     = 1'b0;
    CSR_WE    = 1'b0;
    MEM_RE1   = 1'b0;
    MEM_RE2   = 1'b0;
    MEM_WE2   = 1'b0;
    RESET     = 1'b0;
    INT_TAKEN = 1'b0;
    EXC_TAKEN = 1'b0;
    EXC_CAUSE = 2'd0;
    case (state_q)
      ST_INIT:  RESET   = 1'b1;
      ST_FETCH: MEM_RE1 = 1'b1;
      ST_EXEC: begin
        if (OPCODE == OP_LOAD) begin
          MEM_RE2 = 1'b1;
        end else if (OPCODE == OP_STORE) begin
          MEM_WE2 = 1'b1;
          PC_WR   = DMEM_RDY;
        end else if (OPCODE == OP_BRANCH) begin
          PC_WR = 1'b1;
        end else if (OPCODE == OP_SYSTEM) begin
          PC_WR  = 1'b1;
          RF_WR  = (FUNC3 != 3'd0);
          CSR_WE = (FUNC3 != 3'd0);
        end else if (!(CHECK_ILLEGAL && !is_legal_op(OPCODE))) begin
          RF_WR = 1'b1;
          PC_WR = 1'b1;
        end
      end
      ST_LDWAIT: MEM_RE2 = 1'b1;
      ST_STWAIT: begin
        MEM_WE2 = 1'b1;
        PC_WR   = DMEM_RDY;
      end
      ST_WB: begin
        RF_WR = 1'b1;
        PC_WR = 1'b1;
      end
      ST_INTR: begin
        PC_WR     = 1'b1;
        CSR_WE    = 1'b1;
        INT_TAKEN = 1'b1;
      end
      ST_TRAP: begin
        PC_WR     = 1'b1;
        CSR_WE    = 1'b1;
        EXC_TAKEN = 1'b1;
        EXC_CAUSE = cause_q;
      end
      default: RESET = 1'b1;
    endcase
  end

  assign STATE = state_q;

  // A store's EXEC cycle with DMEM_RDY low already spends one cycle of its data budget.
  always_comb begin
    timer_inc = 1'b0;
    case (state_q)
      ST_FETCH:             timer_inc = !IMEM_RDY;
      ST_EXEC:              timer_inc = store_stall;
      ST_LDWAIT, ST_STWAIT: timer_inc = !DMEM_RDY;
      default:              timer_inc = 1'b0;
    endcase
  end

  assign timer_clr = (state_d != state_q);

  cu_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (timer_clr),
    .inc    (timer_inc),
    .expired(timer_expired)
  );

endmodule

// File: tb/tb_cu_fsm_ws.sv
// Randomized bench for cu_fsm_ws: builds per-instruction expected cycle
// sequences from the control-unit rules and replays them against the DUTs.
module tb_cu_fsm_ws;

  localparam logic [8:0] F_PC   = 9'h001;
  localparam logic [8:0] F_RF   = 9'h002;
  localparam logic [8:0] F_CSR  = 9'h004;
  localparam logic [8:0] F_RE1  = 9'h008;
  localparam logic [8:0] F_RE2  = 9'h010;
  localparam logic [8:0] F_WE2  = 9'h020;
  localparam logic [8:0] F_RSTO = 9'h040;
  localparam logic [8:0] F_INT  = 9'h080;
  localparam logic [8:0] F_EXC  = 9'h100;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYS    = 7'b1110011;
  localparam logic [6:0] ADD    = 7'b0110011;
  localparam logic [6:0] BAD    = 7'b1111111;

  typedef struct {
    logic        rst;
    logic        intr;
    logic        mie;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        irdy;
    logic        drdy;
    logic [13:0] exp;
    string       tag;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, intr, mie, irdy, drdy;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        pc_a, rf_a, csr_a, re1_a, re2_a, we2_a, rsto_a, int_a, exc_a;
  logic        pc_b, rf_b, csr_b, re1_b, re2_b, we2_b, rsto_b, int_b, exc_b;
  logic [1:0]  cause_a, cause_b;
  logic [2:0]  state_a, state_b;
  logic [13:0] obs_a, obs_b;

  cyc_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;
  bit   noise_intr = 1'b0;
  logic [6:0] op_pool [12];

  always #5 clk = ~clk;

  assign obs_a = {state_a, cause_a, exc_a, int_a, rsto_a, we2_a, re2_a, re1_a, csr_a, rf_a, pc_a};
  assign obs_b = {state_b, cause_b, exc_b, int_b, rsto_b, we2_b, re2_b, re1_b, csr_b, rf_b, pc_b};

  cu_fsm_ws #(.TIMEOUT(4), .CHECK_ILLEGAL(1'b1)) dut_a (
    .CLK(clk), .RST(rst_a), .INTR(intr), .CSR_MIE(mie), .OPCODE(op), .FUNC3(f3),
    .IMEM_RDY(irdy), .DMEM_RDY(drdy), .PC_WR(pc_a), .RF_WR(rf_a), .CSR_WE(csr_a),
    .MEM_RE1(re1_a), .MEM_RE2(re2_a), .MEM_WE2(we2_a), .RESET(rsto_a),
    .INT_TAKEN(int_a), .EXC_TAKEN(exc_a), .EXC_CAUSE(cause_a), .STATE(state_a)
  );

  cu_fsm_ws #(.TIMEOUT(0), .CHECK_ILLEGAL(1'b0)) dut_b (
    .CLK(clk), .RST(rst_b), .INTR(intr), .CSR_MIE(mie), .OPCODE(op), .FUNC3(f3),
    .IMEM_RDY(irdy), .DMEM_RDY(drdy), .PC_WR(pc_b), .RF_WR(rf_b), .CSR_WE(csr_b),
    .MEM_RE1(re1_b), .MEM_RE2(re2_b), .MEM_WE2(we2_b), .RESET(rsto_b),
    .INT_TAKEN(int_b), .EXC_TAKEN(exc_b), .EXC_CAUSE(cause_b), .STATE(state_b)
  );

  function automatic logic [13:0] o(input int st, input logic [8:0] flags, input int cause = 0);
    return {3'(st), 2'(cause), flags};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_legal(input logic [6:0] v);
    return v inside {LOAD, STORE, BRANCH, SYS, ADD, 7'b0010011, 7'b1101111,
                     7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  task automatic push(input logic [6:0] o_v, input logic [2:0] f_v, input logic ir,
                      input logic dr, input logic in, input logic mi,
                      input logic [13:0] e, input string t, input logic r = 1'b1);
    cyc_t c;
    c.rst = r; c.op = o_v; c.f3 = f_v; c.irdy = ir; c.drdy = dr;
    c.intr = in; c.mie = mi; c.exp = e; c.tag = t;
    q.push_back(c);
  endtask

  // Non-retiring cycle: opcode and INTR are don't-care noise.
  task automatic pushNoise(input logic ir, input logic dr, input logic [13:0] e,
                           input string t, input logic r = 1'b1);
    push(7'($urandom), 3'($urandom), ir, dr, noise_intr | rb(), noise_intr | rb(), e, t, r);
  endtask

  task automatic genInit();
    pushNoise(rb(), rb(), o(0, F_RSTO), "init");
  endtask

  task automatic genTrap(input int cause);
    pushNoise(rb(), rb(), o(7, F_PC | F_CSR | F_EXC, cause), "trap");
  endtask

  task automatic genRetire(input logic [6:0] opc, input logic [2:0] fn, input logic ir,
                           input logic dr, input logic [13:0] e, input string t,
                           input logic in, input logic mi);
    push(opc, fn, ir, dr, in, mi, e, t);
    if (in && mi) pushNoise(rb(), rb(), o(4, F_PC | F_CSR | F_INT), "intr");
  endtask

  task automatic genInstr(input int tmo, input bit ci, input logic [6:0] opc,
                          input logic [2:0] fn, input int iw, input int dw,
                          input logic in, input logic mi);
    logic [8:0] fl;
    if (tmo != 0 && iw >= tmo) begin
      for (int i = 0; i < tmo; i++) pushNoise(1'b0, rb(), o(1, F_RE1), "fetch_wait");
      genTrap(2);
      return;
    end
    for (int i = 0; i < iw; i++) pushNoise(1'b0, rb(), o(1, F_RE1), "fetch_wait");
    pushNoise(1'b1, rb(), o(1, F_RE1), "fetch_rdy");
    if (opc == LOAD) begin
      push(opc, fn, rb(), rb(), rb(), rb(), o(2, F_RE2), "exec_load");
      if (tmo != 0 && dw >= tmo) begin
        for (int i = 0; i < tmo; i++) pushNoise(rb(), 1'b0, o(5, F_RE2), "ldwait");
        genTrap(3);
        return;
      end
      for (int i = 0; i < dw; i++) pushNoise(rb(), 1'b0, o(5, F_RE2), "ldwait");
      pushNoise(rb(), 1'b1, o(5, F_RE2), "ldwait_rdy");
      genRetire(7'($urandom), 3'($urandom), rb(), rb(), o(3, F_RF | F_PC), "wb", in, mi);
    end else if (opc == STORE) begin
      if (dw == 0) begin
        genRetire(opc, fn, rb(), 1'b1, o(2, F_WE2 | F_PC), "exec_store", in, mi);
        return;
      end
      push(opc, fn, rb(), 1'b0, rb(), rb(), o(2, F_WE2), "exec_store_wait");
      if (tmo != 0 && dw >= tmo) begin
        for (int i = 0; i < tmo - 1; i++) pushNoise(rb(), 1'b0, o(6, F_WE2), "stwait");
        genTrap(3);
        return;
      end
      for (int i = 0; i < dw - 1; i++) pushNoise(rb(), 1'b0, o(6, F_WE2), "stwait");
      genRetire(7'($urandom), 3'($urandom), rb(), 1'b1, o(6, F_WE2 | F_PC), "stwait_rdy", in, mi);
    end else if (ci && !is_legal(opc)) begin
      push(opc, fn, rb(), rb(), rb(), rb(), o(2, 9'h000), "exec_illegal");
      genTrap(1);
    end else begin
      if (opc == BRANCH || (opc == SYS && fn == 3'd0)) fl = F_PC;
      else if (opc == SYS) fl = F_RF | F_PC | F_CSR;
      else fl = F_RF | F_PC;
      genRetire(opc, fn, rb(), rb(), o(2, fl), "exec", in, mi);
    end
  endtask

  task automatic genLoadReset(input int k);
    pushNoise(1'b1, rb(), o(1, F_RE1), "fetch_rdy");
    push(LOAD, 3'd2, rb(), rb(), rb(), rb(), o(2, F_RE2), "exec_load");
    for (int i = 0; i < k; i++) pushNoise(rb(), 1'b0, o(5, F_RE2), "ldwait");
    pushNoise(rb(), 1'b1, o(5, F_RE2), "ldwait_rst", 1'b0);
    genInit();
  endtask

  task automatic genRandom(input int tmo, input bit ci, input int n);
    for (int i = 0; i < n; i++) begin
      genInstr(tmo, ci, op_pool[$urandom_range(0, 11)], 3'($urandom),
               $urandom_range(0, 5), $urandom_range(0, 5), rb(), rb());
    end
  endtask

  task automatic applyStimulus(input int sel, input cyc_t c);
    rst_a = (sel == 0) ? c.rst : 1'b0;
    rst_b = (sel == 1) ? c.rst : 1'b0;
    intr  = c.intr;
    mie   = c.mie;
    op    = c.op;
    f3    = c.f3;
    irdy  = c.irdy;
    drdy  = c.drdy;
  endtask

  task automatic checkOutput(input string tag, input logic [13:0] got, input logic [13:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got state=%0d cause=%0d flags=%03h, expected state=%0d cause=%0d flags=%03h",
               tag, got[13:11], got[10:9], got[8:0], want[13:11], want[10:9], want[8:0]);
    end
  endtask

  task automatic runQueue(input int sel);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      applyStimulus(sel, c);
      #1;
      cyc_no++;
      checkOutput($sformatf("%s_%s@%0d", sel ? "B" : "A", c.tag, cyc_no),
                  sel ? obs_b : obs_a, c.exp);
    end
  endtask

  initial begin
    op_pool = '{LOAD, STORE, BRANCH, SYS, ADD, 7'b0010011, 7'b1101111,
                7'b1100111, 7'b0110111, 7'b0010111, BAD, 7'b0001111};
    rst_a = 1'b0; rst_b = 1'b0; intr = 1'b0; mie = 1'b0;
    op = 7'd0; f3 = 3'd0; irdy = 1'b0; drdy = 1'b0;
    @(posedge clk);

    // DUT A: TIMEOUT=4, illegal opcodes trap
    pushNoise(rb(), rb(), o(0, F_RSTO), "reset_hold", 1'b0);
    genInit();
    genInstr(4, 1, ADD, 3'd0, 3, 0, 1'b0, 1'b0);
    genInstr(4, 1, LOAD, 3'd2, 0, 2, 1'b1, 1'b1);
    genInstr(4, 1, LOAD, 3'd2, 0, 1, 1'b1, 1'b0);
    genInstr(4, 1, STORE, 3'd2, 0, 99, 1'b1, 1'b1);
    genInstr(4, 1, BAD, 3'd0, 0, 0, 1'b1, 1'b1);
    genInstr(4, 1, ADD, 3'd0, 10, 0, 1'b0, 1'b0);
    genInstr(4, 1, LOAD, 3'd0, 3, 3, 1'b0, 1'b0);
    genInstr(4, 1, STORE, 3'd0, 0, 3, 1'b0, 1'b0);
    genInstr(4, 1, STORE, 3'd0, 0, 0, 1'b1, 1'b1);
    genInstr(4, 1, LOAD, 3'd0, 0, 4, 1'b0, 1'b0);
    genInstr(4, 1, SYS, 3'd0, 0, 0, 1'b0, 1'b0);
    genInstr(4, 1, SYS, 3'd1, 1, 0, 1'b0, 1'b0);
    genInstr(4, 1, BRANCH, 3'd1, 0, 0, 1'b0, 1'b0);
    genLoadReset(2);
    runQueue(0);
    noise_intr = 1'b1;
    genInstr(4, 1, ADD, 3'd0, 2, 0, 1'b0, 1'b1);
    runQueue(0);
    noise_intr = 1'b0;
    genRandom(4, 1, 40);
    runQueue(0);

    // DUT B: timeouts disabled, unknown opcodes execute as ALU ops
    genInit();
    genInstr(0, 0, BAD, 3'd0, 0, 0, 1'b0, 1'b0);
    genInstr(0, 0, ADD, 3'd0, 10, 0, 1'b0, 1'b0);
    genInstr(0, 0, LOAD, 3'd0, 0, 9, 1'b1, 1'b1);
    genInstr(0, 0, STORE, 3'd0, 0, 8, 1'b0, 1'b0);
    genRandom(0, 0, 20);
    runQueue(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cu_fsm_ws.md
# cu_fsm_ws

Multicycle control-unit FSM for the RISC-V MCU with memory ready handshakes and bus timeouts. It sequences fetch, execute, load/store wait and writeback, and drives the write enables and memory strobes for the datapath. It also handles interrupt entry and synchronous exception traps. It sits between the decoder (OPCODE/FUNC3) and the datapath/CSR file, and supports instruction and data memories with variable wait states.

## Interface
- TIMEOUT, default 16: maximum wait cycles for IMEM_RDY/DMEM_RDY before a bus-timeout trap; 0 disables timeouts.
- CHECK_ILLEGAL, default 1: 1 = unknown opcodes trap; 0 = treat them as one-cycle ALU ops.
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-low.
- INTR  in  1  external interrupt request (level).
- CSR_MIE  in  1  global interrupt enable.
- OPCODE  in  7  instruction opcode.
- FUNC3  in  3  instruction funct3.
- IMEM_RDY  in  1  instruction memory data valid.
- DMEM_RDY  in  1  data memory access complete.
- PC_WR, RF_WR, CSR_WE  out  1 each  PC, register file and CSR write enables.
- MEM_RE1, MEM_RE2, MEM_WE2  out  1 each  instruction read, data read and data write strobes.
- RESET  out  1  datapath reset.
- INT_TAKEN  out  1  interrupt entry.
- EXC_TAKEN  out  1  exception entry.
- EXC_CAUSE  out  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout. Valid only with EXC_TAKEN; 0 otherwise.
- STATE  out  3  current state, for debug.

## Operation
- States: INIT, FETCH, EXEC, LDWAIT, STWAIT, WB, INTR, TRAP.
- Outputs not listed for a state are 0.
- INIT: RESET=1. Next state FETCH.
- FETCH: MEM_RE1=1. Stay until IMEM_RDY=1, then go to EXEC.
- EXEC, by OPCODE:
  - Load (0000011): MEM_RE2=1, next LDWAIT.
  - Store (0100011): MEM_WE2=1, PC_WR=DMEM_RDY. If DMEM_RDY=1 the instruction retires; otherwise next STWAIT.
  - Branch (1100011): PC_WR=1, retire.
  - System (1110011) with FUNC3=0 (mret): PC_WR=1, retire.
  - System (1110011) with FUNC3≠0: RF_WR, PC_WR, CSR_WE=1, retire.
  - Other legal opcodes (0110011, 0010011, 1101111, 1100111, 0110111, 0010111): RF_WR, PC_WR=1, retire.
  - Any other opcode with CHECK_ILLEGAL=1: no enables asserted, next TRAP with cause 1.
- LDWAIT: MEM_RE2=1. Stay until DMEM_RDY=1, then go to WB.
- STWAIT: MEM_WE2=1. When DMEM_RDY=1: PC_WR=1, retire.
- WB: RF_WR, PC_WR=1, retire.
- Retire: next state is INTR if INTR&CSR_MIE, else FETCH.
- INTR: PC_WR, CSR_WE, INT_TAKEN=1. Next FETCH.
- TRAP: PC_WR, CSR_WE, EXC_TAKEN=1, EXC_CAUSE held from entry. Next FETCH. Interrupts are not checked on the TRAP→FETCH transition.
- Timeout counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, LDWAIT or STWAIT with the corresponding RDY=0.
  - If TIMEOUT≠0 and the counter equals TIMEOUT-1 while RDY is still 0, next state is TRAP. Cause is 2 from FETCH, 3 from LDWAIT/STWAIT.
  - Counter width is $clog2(TIMEOUT+1), minimum 1.
- Priority within a cycle: RST > RDY arrival > timeout > interrupt. RDY on the final allowed cycle counts as success.

## Timing
- Sampling: state and cause register update on posedge CLK. RST=0 at an edge forces state INIT, counter 0 and cause 0 next cycle, from any state, including mid-wait.
- Reset outputs: in INIT, RESET=1 and every other output is 0; STATE=0.
- Output decode: outputs are combinational from state, OPCODE, FUNC3 and DMEM_RDY (store PC_WR only). There is no registered output latency.
- Latencies with zero wait states:
  - ALU, branch, CSR, store: 2 cycles (FETCH, EXEC).
  - Load: 4 cycles (FETCH, EXEC, LDWAIT, WB).
  - Each RDY-low cycle adds one cycle.
- Handshake: the strobe is held high continuously until the RDY cycle inclusive, and drops on the next cycle. The RDY input is ignored outside its wait state.
- Interrupt entry adds 1 cycle after retirement. INTR is sampled only in the retiring cycle; this deliberately differs from CU_FSM.

## Structure
- Shared package cu_pkg holds:
  - the state enum (INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4, LDWAIT=5, STWAIT=6, TRAP=7);
  - opcode localparams;
  - EXC_CAUSE codes.
- One sub-module, cu_wait_timer (parameter TIMEOUT; inputs clr, inc; output expired), owns the timeout counter.

## Test plan
- RST=0 for 2 cycles, then RST=1 → STATE=0 with RESET=1, then FETCH (MEM_RE1=1). Asserting RST=0 mid-LDWAIT returns to INIT on the next edge.
- ADD (0110011), IMEM_RDY high for 1 cycle after 3 low → MEM_RE1 high for 4 cycles; EXEC asserts RF_WR=PC_WR=1; total 5 cycles.
- Load, DMEM_RDY low for 2 LDWAIT cycles → MEM_RE2 high for 4 cycles (EXEC plus 3 in LDWAIT); WB has RF_WR=PC_WR=1.
- Store with DMEM_RDY held 0 and TIMEOUT=4 → 3 STWAIT cycles, then TRAP with EXC_TAKEN=1, EXC_CAUSE=3, PC_WR=CSR_WE=1; MEM_WE2=0 in TRAP.
- OPCODE=1111111, CHECK_ILLEGAL=1 → TRAP with cause 1 and RF_WR=0 throughout. With CHECK_ILLEGAL=0 → RF_WR=PC_WR=1 in EXEC.
- INTR=1, CSR_MIE=1 during WB of a load → INTR state next (INT_TAKEN=1), then FETCH. INTR with CSR_MIE=0 → no INTR state. INTR asserted only during FETCH → ignored.
